avalon_write_buffer: RTL and testbench
======================================

Name: avalon_write_buffer

Overview:
Avalon-MM bridge with posted writes, placed between a bus master (slave port s0) and memory (master port m0).
- Writes are queued in a FIFO and acknowledged immediately; the FIFO drains to m0 in order.
- Reads check the FIFO: a full-word hit is answered locally, a miss is forwarded to m0.
- Only one read is outstanding at a time.

Parameters:
DEPTH, 4, number of write-FIFO entries (power of two, at least 2)
AW, 32, address width
DW, 32, data width (byteenable width is DW/8)

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
avs_s0_address  in  AW  slave address
avs_s0_readdata  out  DW  slave read data
avs_s0_writedata  in  DW  slave write data
avs_s0_byteenable  in  DW/8  slave byte enables
avs_s0_read  in  1  slave read strobe
avs_s0_write  in  1  slave write strobe
avs_s0_readdatavalid  out  1  readdata valid, one-cycle pulse
avs_s0_waitrequest  out  1  stall; command is held by the upstream master while high
avs_s0_chipselect  in  1  qualifies read/write
avm_m0_address  out  AW  master address (registered)
avm_m0_readdata  in  DW  master read data
avm_m0_writedata  out  DW  master write data (registered)
avm_m0_byteenable  out  DW/8  master byte enables (registered)
avm_m0_read  out  1  master read strobe (registered)
avm_m0_write  out  1  master write strobe (registered)
avm_m0_readdatavalid  in  1  master read data valid
avm_m0_waitrequest  in  1  downstream stall
avm_m0_chipselect  out  1  high whenever m0 read or write is high

Behaviour:
- Reset (async): FIFO empty, state IDLE, all avm_m0_* outputs 0, avs_s0_readdatavalid 0, avs_s0_readdata 0, avs_s0_waitrequest 1 while reset is asserted.
- Write accept: chipselect and write and FIFO not full -> waitrequest 0 that cycle and {address, writedata, byteenable} is pushed at the edge. If the FIFO is full (registered count equals DEPTH), waitrequest is 1.
- Writes are accepted in every state, including while a read is outstanding.
- Read hit check: search all valid entries for an equal address; the newest matching entry wins.
- Full hit (matching entry has byteenable all ones and no read is outstanding):
  - waitrequest 0 that cycle.
  - Next cycle: readdatavalid=1 and readdata = the entry's data.
- Partial hit (a match exists but the newest match lacks full byteenable): waitrequest 1 until the FIFO is empty, then the read is treated as a miss.
- Read miss in IDLE:
  - Capture the command into the m0 registers (read=1, chipselect=1), go to RD, keep slave waitrequest 1.
  - In RD, on the cycle avm_m0_waitrequest=0: slave waitrequest 0, m0 read/chipselect cleared at the edge, go to RDWAIT.
  - In RDWAIT: avs_s0_readdata = avm_m0_readdata and avs_s0_readdatavalid = avm_m0_readdatavalid (combinational pass-through).
  - On readdatavalid, return to IDLE. New slave reads stall (waitrequest 1) in RD and RDWAIT.
- Write drain: in IDLE, with no slave read pending and the FIFO non-empty:
  - Load the head entry into the m0 registers (write=1, chipselect=1) and go to WR.
  - In WR, on avm_m0_waitrequest=0, pop the head (the entry stays visible to the hit check until popped) and clear write/chipselect; return to IDLE.
  - Each drained write costs at least two cycles.
- Priority in IDLE: a pending slave read miss is served before draining writes (reads bypass non-conflicting writes).
- Push and pop in the same cycle: both take effect and the count is unchanged.
- Chipselect low: read/write ignored and waitrequest 0.
- Read and write both asserted: treated as a write.
- Write order at m0 equals slave acceptance order. No write merging.

Test Plan:
- Read miss: cs=1, read, address 0x10001000, byteenable 0xF, m0 waitrequest held 1 then 0 -> m0 read asserted with address 0x10001000; slave waitrequest stays 1 until m0 accepts; m0 readdata 0x50505050 appears on avs_s0_readdata with readdatavalid=1.
- Posted writes with m0 stalled: write 0xA0A0A0A0@0x00002000, then 0x21212121@0x00003000 on consecutive cycles -> slave waitrequest 0 both cycles; m0 write shows 0x00002000 first, held until m0 waitrequest drops, then 0x00003000.
- Full hit: write 0xDEADBEEF@0x100, m0 stalled, then read 0x100 -> readdatavalid=1 with 0xDEADBEEF the next cycle and no m0 read issued. Partial-byteenable write followed by a read of the same address -> slave stalls until the FIFO is empty, then the read is forwarded.
- Full FIFO: DEPTH+1 writes with m0 stalled -> the last write sees waitrequest 1 until one entry drains.
- Reset mid-drain: assert reset while m0 write is pending -> m0 write/chipselect go 0 immediately, FIFO empty, waitrequest 1 during reset.

Source files
------------

// File: rtl/avalon_write_buffer.sv
// Avalon-MM posted-write bridge. Slave writes go into a small FIFO that drains to
// m0 in order. Slave reads are answered from the FIFO on a full-word hit and forwarded to m0 otherwise.
module avalon_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   avs_s0_address,
    output logic [DW-1:0]   avs_s0_readdata,
    input  logic [DW-1:0]   avs_s0_writedata,
    input  logic [DW/8-1:0] avs_s0_byteenable,
    input  logic            avs_s0_read,
    input  logic            avs_s0_write,
    output logic            avs_s0_readdatavalid,
    output logic            avs_s0_waitrequest,
    input  logic            avs_s0_chipselect,
    output logic [AW-1:0]   avm_m0_address,
    input  logic [DW-1:0]   avm_m0_readdata,
    output logic [DW-1:0]   avm_m0_writedata,
    output logic [DW/8-1:0] avm_m0_byteenable,
    output logic            avm_m0_read,
    output logic            avm_m0_write,
    input  logic            avm_m0_readdatavalid,
    input  logic            avm_m0_waitrequest,
    output logic            avm_m0_chipselect
);

    localparam int BW = DW / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDWAIT
    } state_t;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [BW-1:0] be_mem   [DEPTH];

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] m0_addr_q, m0_addr_d;
    logic [DW-1:0] m0_wdata_q, m0_wdata_d;
    logic [BW-1:0] m0_be_q, m0_be_d;
    logic          m0_read_q, m0_read_d;
    logic          m0_write_q, m0_write_d;
    logic          m0_cs_q, m0_cs_d;
    logic          rdv_q, rdv_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          wr_req, rd_req, rd_miss, fifo_full;
    logic          push, pop, s0_wait;
    logic          hit_any, hit_full;
    logic [DW-1:0] hit_data;
    logic [BW-1:0] hit_be;

    logic [PW-1:0]    slot_idx [DEPTH];
    logic [DEPTH-1:0] slot_match;

    assign wr_req    = avs_s0_chipselect && avs_s0_write;
    assign rd_req    = avs_s0_chipselect && avs_s0_read && !avs_s0_write;
    assign fifo_full = (count_q == CW'(DEPTH));

    // Slot gi is the gi-th oldest entry; DEPTH is a power of two so the pointer wraps for free.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_idx[gi]   = head_q + PW'(gi);
        assign slot_match[gi] = (CW'(gi) < count_q) &&
                                (addr_mem[slot_idx[gi]] == avs_s0_address);
    end

    always_comb begin
        hit_any  = 1'b0;
        hit_data = '0;
        hit_be   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_match[i]) begin
                hit_any  = 1'b1;
                hit_data = data_mem[slot_idx[i]];
                hit_be   = be_mem[slot_idx[i]];
            end
        end
    end

    assign hit_full = &hit_be;
    assign rd_miss  = rd_req && !hit_any;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        m0_addr_d  = m0_addr_q;
        m0_wdata_d = m0_wdata_q;
        m0_be_d    = m0_be_q;
        m0_read_d  = m0_read_q;
        m0_write_d = m0_write_q;
        m0_cs_d    = m0_cs_q;
        rdv_d      = 1'b0;
        rdata_d    = rdata_q;
        s0_wait    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;

        if (wr_req) begin
            push    = !fifo_full;
            s0_wait = fifo_full;
        end else if (rd_req) begin
            s0_wait = 1'b1;
            if (state_q == S_RD) begin
                s0_wait = avm_m0_waitrequest;
            end else if (state_q != S_RDWAIT && hit_any && hit_full) begin
                s0_wait = 1'b0;
                rdv_d   = 1'b1;
                rdata_d = hit_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                // A read miss bypasses queued writes; a partial hit lets the drain run until it clears.
                if (rd_miss) begin
                    m0_addr_d = avs_s0_address;
                    m0_be_d   = avs_s0_byteenable;
                    m0_read_d = 1'b1;
                    m0_cs_d   = 1'b1;
                    state_d   = S_RD;
                end else if (count_q != '0) begin
                    m0_addr_d  = addr_mem[head_q];
                    m0_wdata_d = data_mem[head_q];
                    m0_be_d    = be_mem[head_q];
                    m0_write_d = 1'b1;
                    m0_cs_d    = 1'b1;
                    state_d    = S_WR;
                end
            end
            S_WR: begin
                if (!avm_m0_waitrequest) begin
                    pop        = 1'b1;
                    m0_write_d = 1'b0;
                    m0_cs_d    = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_RD: begin
                if (!avm_m0_waitrequest) begin
                    m0_read_d = 1'b0;
                    m0_cs_d   = 1'b0;
                    state_d   = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (avm_m0_readdatavalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= avs_s0_address;
            data_mem[tail_q] <= avs_s0_writedata;
            be_mem[tail_q]   <= avs_s0_byteenable;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            m0_addr_q  <= '0;
            m0_wdata_q <= '0;
            m0_be_q    <= '0;
            m0_read_q  <= 1'b0;
            m0_write_q <= 1'b0;
            m0_cs_q    <= 1'b0;
            rdv_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            m0_addr_q  <= m0_addr_d;
            m0_wdata_q <= m0_wdata_d;
            m0_be_q    <= m0_be_d;
            m0_read_q  <= m0_read_d;
            m0_write_q <= m0_write_d;
            m0_cs_q    <= m0_cs_d;
            rdv_q      <= rdv_d;
            rdata_q    <= rdata_d;
        end
    end

    // While a forwarded read is in flight, m0's response is passed straight through.
    assign avs_s0_readdata      = (state_q == S_RDWAIT) ? avm_m0_readdata : rdata_q;
    assign avs_s0_readdatavalid = (state_q == S_RDWAIT) ? avm_m0_readdatavalid : rdv_q;
    assign avs_s0_waitrequest   = reset || s0_wait;

    assign avm_m0_address    = m0_addr_q;
    assign avm_m0_writedata  = m0_wdata_q;
    assign avm_m0_byteenable = m0_be_q;
    assign avm_m0_read       = m0_read_q;
    assign avm_m0_write      = m0_write_q;
    assign avm_m0_chipselect = m0_cs_q;

endmodule

// File: tb/tb_avalon_write_buffer.sv
// Directed bench for avalon_write_buffer: read miss, posted writes, full/partial hits,
// full FIFO back-pressure and reset during a drain.
module tb_avalon_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] avs_s0_address;
    logic [DW-1:0] avs_s0_readdata;
    logic [DW-1:0] avs_s0_writedata;
    logic [3:0]    avs_s0_byteenable;
    logic          avs_s0_read;
    logic          avs_s0_write;
    logic          avs_s0_readdatavalid;
    logic          avs_s0_waitrequest;
    logic          avs_s0_chipselect;
    logic [AW-1:0] avm_m0_address;
    logic [DW-1:0] avm_m0_readdata;
    logic [DW-1:0] avm_m0_writedata;
    logic [3:0]    avm_m0_byteenable;
    logic          avm_m0_read;
    logic          avm_m0_write;
    logic          avm_m0_readdatavalid;
    logic          avm_m0_waitrequest;
    logic          avm_m0_chipselect;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .avs_s0_address       (avs_s0_address),
        .avs_s0_readdata      (avs_s0_readdata),
        .avs_s0_writedata     (avs_s0_writedata),
        .avs_s0_byteenable    (avs_s0_byteenable),
        .avs_s0_read          (avs_s0_read),
        .avs_s0_write         (avs_s0_write),
        .avs_s0_readdatavalid (avs_s0_readdatavalid),
        .avs_s0_waitrequest   (avs_s0_waitrequest),
        .avs_s0_chipselect    (avs_s0_chipselect),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_writedata     (avm_m0_writedata),
        .avm_m0_byteenable    (avm_m0_byteenable),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_write         (avm_m0_write),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .avm_m0_chipselect    (avm_m0_chipselect)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %0d %s observed=%h expected=%h", checks, tag, obs, exp);
    endtask

    task automatic slave(input logic cs, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [3:0] be);
        avs_s0_chipselect = cs;
        avs_s0_read       = rd;
        avs_s0_write      = wr;
        avs_s0_address    = addr;
        avs_s0_writedata  = data;
        avs_s0_byteenable = be;
    endtask

    task automatic idle_slave();
        slave(1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    initial begin
        reset                = 1'b1;
        avm_m0_readdata      = '0;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_waitrequest   = 1'b1;
        idle_slave();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_s0_wait", avs_s0_waitrequest, 1'b1);
        chk("rst_m0_write", avm_m0_write, 1'b0);
        chk("rst_m0_read", avm_m0_read, 1'b0);
        chk("rst_m0_cs", avm_m0_chipselect, 1'b0);
        chk("rst_s0_rdv", avs_s0_readdatavalid, 1'b0);
        chk("rst_s0_rdata", avs_s0_readdata, 32'h0);
        reset = 1'b0;

        // Chipselect low: strobes ignored, no stall, nothing queued
        @(negedge clk);
        slave(1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h5555_5555, 4'hF);
        #1;
        chk("cs_low_wait", avs_s0_waitrequest, 1'b0);
        @(negedge clk);
        idle_slave();
        @(negedge clk);
        #1;
        chk("cs_low_no_write", avm_m0_write, 1'b0);

        // Read miss forwarded to m0
        slave(1'b1, 1'b1, 1'b0, 32'h1000_1000, '0, 4'hF);
        #1;
        chk("miss_wait_idle", avs_s0_waitrequest, 1'b1);
        @(negedge clk);
        #1;
        chk("miss_m0_read", avm_m0_read, 1'b1);
        chk("miss_m0_cs", avm_m0_chipselect, 1'b1);
        chk("miss_m0_addr", avm_m0_address, 32'h1000_1000);
        chk("miss_wait_rd_stalled", avs_s0_waitrequest, 1'b1);
        avm_m0_waitrequest = 1'b0;
        #1;
        chk("miss_wait_rd_accept", avs_s0_waitrequest, 1'b0);
        @(negedge clk);
        idle_slave();
        avm_m0_waitrequest   = 1'b1;
        avm_m0_readdata      = 32'h5050_5050;
        avm_m0_readdatavalid = 1'b1;
        #1;
        chk("miss_m0_read_cleared", avm_m0_read, 1'b0);
        chk("miss_s0_rdv", avs_s0_readdatavalid, 1'b1);
        chk("miss_s0_rdata", avs_s0_readdata, 32'h5050_5050);
        @(negedge clk);
        avm_m0_readdatavalid = 1'b0;
        #1;
        chk("miss_rdv_pulse", avs_s0_readdatavalid, 1'b0);

        // Posted writes with m0 stalled
        slave(1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'hA0A0_A0A0, 4'hF);
        #1;
        chk("post_wait0", avs_s0_waitrequest, 1'b0);
        @(negedge clk);
        slave(1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h2121_2121, 4'hF);
        #1;
        chk("post_wait1", avs_s0_waitrequest, 1'b0);
        @(negedge clk);
        idle_slave();
        #1;
        chk("post_first_write", avm_m0_write, 1'b1);
        chk("post_first_addr", avm_m0_address, 32'h0000_2000);
        chk("post_first_data", avm_m0_writedata, 32'hA0A0_A0A0);
        @(negedge clk);
        #1;
        chk("post_first_held", avm_m0_address, 32'h0000_2000);
        avm_m0_waitrequest = 1'b0;
        @(negedge clk);
        avm_m0_waitrequest = 1'b1;
        #1;
        chk("post_gap", avm_m0_write, 1'b0);
        @(negedge clk);
        #1;
        chk("post_second_write", avm_m0_write, 1'b1);
        chk("post_second_addr", avm_m0_address, 32'h0000_3000);
        chk("post_second_data", avm_m0_writedata, 32'h2121_2121);
        avm_m0_waitrequest = 1'b0;
        @(negedge clk);
        avm_m0_waitrequest = 1'b1;
        #1;
        chk("post_drained", avm_m0_write, 1'b0);

        // Full hit answered locally
        slave(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("hit_write_wait", avs_s0_waitrequest, 1'b0);
        @(negedge clk);
        slave(1'b1, 1'b1, 1'b0, 32'h0000_0100, '0, 4'hF);
        #1;
        chk("hit_read_wait", avs_s0_waitrequest, 1'b0);
        @(negedge clk);
        idle_slave();
        #1;
        chk("hit_rdv", avs_s0_readdatavalid, 1'b1);
        chk("hit_rdata", avs_s0_readdata, 32'hDEAD_BEEF);
        chk("hit_no_m0_read", avm_m0_read, 1'b0);
        avm_m0_waitrequest = 1'b0;
        @(negedge clk);
        avm_m0_waitrequest = 1'b1;
        #1;
        chk("hit_rdv_pulse", avs_s0_readdatavalid, 1'b0);
        chk("hit_drained", avm_m0_write, 1'b0);

        // Partial hit: stall until the FIFO empties, then forward
        slave(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h1122_3344, 4'h3);
        #1;
        chk("part_write_wait", avs_s0_waitrequest, 1'b0);
        @(negedge clk);
        slave(1'b1, 1'b1, 1'b0, 32'h0000_0200, '0, 4'hF);
        #1;
        chk("part_wait_queued", avs_s0_waitrequest, 1'b1);
        @(negedge clk);
        #1;
        chk("part_wait_draining", avs_s0_waitrequest, 1'b1);
        chk("part_m0_write", avm_m0_write, 1'b1);
        chk("part_m0_be", avm_m0_byteenable, 4'h3);
        chk("part_no_m0_read", avm_m0_read, 1'b0);
        avm_m0_waitrequest = 1'b0;
        #1;
        chk("part_wait_pop", avs_s0_waitrequest, 1'b1);
        @(negedge clk);
        avm_m0_waitrequest = 1'b1;
        #1;
        chk("part_wait_empty", avs_s0_waitrequest, 1'b1);
        @(negedge clk);
        #1;
        chk("part_m0_read", avm_m0_read, 1'b1);
        chk("part_m0_addr", avm_m0_address, 32'h0000_0200);
        avm_m0_waitrequest = 1'b0;
        #1;
        chk("part_wait_accept", avs_s0_waitrequest, 1'b0);
        @(negedge clk);
        idle_slave();
        avm_m0_waitrequest   = 1'b1;
        avm_m0_readdata      = 32'h9988_7766;
        avm_m0_readdatavalid = 1'b1;
        #1;
        chk("part_rdata", avs_s0_readdata, 32'h9988_7766);
        @(negedge clk);
        avm_m0_readdatavalid = 1'b0;

        // Full FIFO: DEPTH+1 writes with m0 stalled
        for (int i = 0; i < DEPTH; i++) begin
            slave(1'b1, 1'b0, 1'b1, 32'h0000_0400 + 32'(i * 4), 32'h0000_1000 + 32'(i), 4'hF);
            #1;
            chk($sformatf("full_wait_w%0d", i), avs_s0_waitrequest, 1'b0);
            @(negedge clk);
        end
        slave(1'b1, 1'b0, 1'b1, 32'h0000_0410, 32'h0000_1004, 4'hF);
        #1;
        chk("full_wait_last", avs_s0_waitrequest, 1'b1);
        chk("full_head_addr", avm_m0_address, 32'h0000_0400);
        @(negedge clk);
        #1;
        chk("full_wait_hold", avs_s0_waitrequest, 1'b1);
        avm_m0_waitrequest = 1'b0;
        #1;
        chk("full_wait_pop_cycle", avs_s0_waitrequest, 1'b1);
        @(negedge clk);
        avm_m0_waitrequest = 1'b1;
        #1;
        chk("full_wait_freed", avs_s0_waitrequest, 1'b0);
        @(negedge clk);
        idle_slave();
        #1;
        chk("full_next_write", avm_m0_write, 1'b1);
        chk("full_next_addr", avm_m0_address, 32'h0000_0404);

        // Reset mid-drain
        reset = 1'b1;
        #1;
        chk("rst_mid_m0_write", avm_m0_write, 1'b0);
        chk("rst_mid_m0_cs", avm_m0_chipselect, 1'b0);
        chk("rst_mid_s0_wait", avs_s0_waitrequest, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_fifo_empty_no_drain", avm_m0_write, 1'b0);
        slave(1'b1, 1'b1, 1'b0, 32'h0000_040C, '0, 4'hF);
        #1;
        chk("rst_old_entry_not_hit", avs_s0_waitrequest, 1'b1);
        @(negedge clk);
        #1;
        chk("rst_read_forwarded", avm_m0_read, 1'b1);
        avm_m0_waitrequest = 1'b0;
        @(negedge clk);
        idle_slave();
        avm_m0_waitrequest   = 1'b1;
        avm_m0_readdatavalid = 1'b1;
        @(negedge clk);
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
